// File: rtl/vec_csr_pkg.sv
// Shared definitions for the vector-configuration CSR unit.
// Holds the request opcode and FSM state encodings, the vsew/vlmul
// encodings used for legality checks, and the vtype reset constant.
package vec_csr_pkg;

    typedef enum logic [1:0] {
        CSR_VSETVLI  = 2'b00,
        CSR_VSETIVLI = 2'b01,
        CSR_VSETVL   = 2'b10,
        CSR_RSVD     = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_CALC   = 2'b01,
        ST_COMMIT = 2'b10
    } csr_state_e;

    // vsew encodings (SEW = 8 << vsew)
    localparam logic [2:0] VSEW_8  = 3'b000;
    localparam logic [2:0] VSEW_16 = 3'b001;
    localparam logic [2:0] VSEW_32 = 3'b010;

    // vlmul encodings: 0..3 integer LMUL, 5..7 fractional, 4 reserved
    localparam logic [2:0] VLMUL_1    = 3'b000;
    localparam logic [2:0] VLMUL_RSVD = 3'b100;

    // vill position and reset vtype for the default 32-bit configuration
    localparam int          XLEN_DEF    = 32;
    localparam int          VILL_BIT    = XLEN_DEF - 1;
    localparam logic [31:0] VTYPE_RESET = 32'h8000_0000;

endpackage

// File: rtl/vec_vlmax_calc.sv
// Combinational VLMAX / vtype legality calculator.
// Ports:
//   vsew, vlmul : candidate vtype fields
//   vlmax       : VLEN/SEW scaled by LMUL, XLEN bits
//   illegal     : SEW > ELEN, reserved vlmul, or SEW > ELEN*LMUL for fractional LMUL
module vec_vlmax_calc
    import vec_csr_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int VLEN = 512,
    parameter int ELEN = 32
) (
    input  logic [2:0]      vsew,
    input  logic [2:0]      vlmul,
    output logic [XLEN-1:0] vlmax,
    output logic            illegal
);

    logic [XLEN-1:0] base;
    logic            frac;
    logic [3:0]      frac_sh;
    int unsigned     sew_bits;
    int unsigned     elen_frac;

    always_comb begin
        // elements per register at LMUL=1
        base      = XLEN'(VLEN) >> (3 + vsew);
        frac      = vlmul[2] && (vlmul != VLMUL_RSVD);
        // vlmul 5/6/7 divide by 8/4/2
        frac_sh   = 4'd8 - {1'b0, vlmul};
        vlmax     = frac ? (base >> frac_sh) : (base << vlmul[1:0]);
        sew_bits  = 32'd8 << vsew;
        elen_frac = unsigned'(ELEN) >> frac_sh;
        illegal   = (vsew > VSEW_32) || (vlmul == VLMUL_RSVD) ||
                    (frac && (sew_bits > elen_frac));
    end

endmodule

// File: rtl/vec_csr_unit.sv
// Vector-configuration CSR unit: executes VSETVLI/VSETIVLI/VSETVL,
// holds vl, vtype, vlmax and vstart for the vector datapath.
// Ports:
//   clk, n_rst              : clock, synchronous active-low reset
//   csr_req_valid/ready     : request handshake (ready only in IDLE)
//   csr_op, scalar1/2       : opcode, AVL and requested vtype
//   rs1_is_x0, rd_is_x0     : register-field zero flags for AVL selection
//   vstart_wr_en/data       : direct vstart write
//   resp_valid, resp_vl     : one-cycle response with the new vl
//   vl_o .. vstart_o        : architectural CSR state and vtype slices
module vec_csr_unit
    import vec_csr_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int VLEN = 512,
    parameter int ELEN = 32
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            csr_req_valid,
    output logic            csr_req_ready,
    input  logic [1:0]      csr_op,
    input  logic [XLEN-1:0] scalar1,
    input  logic [XLEN-1:0] scalar2,
    input  logic            rs1_is_x0,
    input  logic            rd_is_x0,
    input  logic            vstart_wr_en,
    input  logic [XLEN-1:0] vstart_wr_data,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_vl,
    output logic [XLEN-1:0] vl_o,
    output logic [XLEN-1:0] vtype_o,
    output logic [XLEN-1:0] vlmax_o,
    output logic [2:0]      vsew_o,
    output logic [2:0]      vlmul_o,
    output logic            vill_o,
    output logic [XLEN-1:0] vstart_o
);

    localparam logic [XLEN-1:0] VTYPE_RST = {1'b1, {(XLEN-1){1'b0}}};

    csr_state_e      state, state_nxt;
    csr_op_e         op_q;
    logic [XLEN-1:0] s1_q, s2_q;
    logic            rs1_x0_q, rd_x0_q;
    logic [XLEN-1:0] vlmax_q;
    logic            ill_q;

    logic [XLEN-1:0] cand_vlmax;
    logic            cand_ill;
    logic            keep_vl;
    logic            ill_full;
    logic [XLEN-1:0] avl;
    logic [XLEN-1:0] new_vl;

    vec_vlmax_calc #(.XLEN(XLEN), .VLEN(VLEN), .ELEN(ELEN)) u_vlmax (
        .vsew    (s2_q[5:3]),
        .vlmul   (s2_q[2:0]),
        .vlmax   (cand_vlmax),
        .illegal (cand_ill)
    );

    // rs1=x0, rd=x0 keeps vl, which is only allowed if VLMAX is unchanged
    assign keep_vl  = (op_q != CSR_VSETIVLI) && rs1_x0_q && rd_x0_q;
    assign ill_full = cand_ill || (s2_q[XLEN-2:8] != '0) || (op_q == CSR_RSVD) ||
                      (keep_vl && (cand_vlmax != vlmax_o));

    always_comb begin
        avl = s1_q;
        if (op_q == CSR_VSETIVLI)
            avl = {{(XLEN-5){1'b0}}, s1_q[4:0]};
        else if (rs1_x0_q)
            avl = rd_x0_q ? vl_o : '1;
    end

    assign new_vl = ill_q ? '0 : ((avl < vlmax_q) ? avl : vlmax_q);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!n_rst) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // FSM next state / handshake
    always_comb begin
        state_nxt     = state;
        csr_req_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                csr_req_ready = 1'b1;
                if (csr_req_valid) state_nxt = ST_CALC;
            end
            ST_CALC:   state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Request capture, calculation and CSR commit
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            op_q       <= CSR_VSETVLI;
            s1_q       <= '0;
            s2_q       <= '0;
            rs1_x0_q   <= 1'b0;
            rd_x0_q    <= 1'b0;
            vlmax_q    <= '0;
            ill_q      <= 1'b0;
            vl_o       <= '0;
            vtype_o    <= VTYPE_RST;
            vlmax_o    <= '0;
            vstart_o   <= '0;
            resp_valid <= 1'b0;
            resp_vl    <= '0;
        end else begin
            resp_valid <= 1'b0;
            if (state == ST_IDLE && csr_req_valid) begin
                op_q     <= csr_op_e'(csr_op);
                s1_q     <= scalar1;
                s2_q     <= scalar2;
                rs1_x0_q <= rs1_is_x0;
                rd_x0_q  <= rd_is_x0;
            end
            if (state == ST_CALC) begin
                vlmax_q <= cand_vlmax;
                ill_q   <= ill_full;
            end
            if (state == ST_COMMIT) begin
                vl_o       <= new_vl;
                vtype_o    <= ill_q ? VTYPE_RST : {1'b0, s2_q[XLEN-2:0]};
                vlmax_o    <= ill_q ? '0 : vlmax_q;
                resp_valid <= 1'b1;
                resp_vl    <= new_vl;
            end
            // commit clear has priority over a direct write
            if (state == ST_COMMIT)
                vstart_o <= '0;
            else if (vstart_wr_en)
                vstart_o <= vstart_wr_data;
        end
    end

    assign vsew_o  = vtype_o[5:3];
    assign vlmul_o = vtype_o[2:0];
    assign vill_o  = vtype_o[XLEN-1];

endmodule

// File: tb/tb_vec_csr_unit.sv
module tb_vec_csr_unit;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        csr_req_valid;
    logic        csr_req_ready;
    logic [1:0]  csr_op;
    logic [31:0] scalar1, scalar2;
    logic        rs1_is_x0, rd_is_x0;
    logic        vstart_wr_en;
    logic [31:0] vstart_wr_data;
    logic        resp_valid;
    logic [31:0] resp_vl, vl_o, vtype_o, vlmax_o, vstart_o;
    logic [2:0]  vsew_o, vlmul_o;
    logic        vill_o;

    int errors = 0;
    int checks = 0;
    int lat;

    always #5 clk = ~clk;

    vec_csr_unit dut (
        .clk(clk), .n_rst(n_rst),
        .csr_req_valid(csr_req_valid), .csr_req_ready(csr_req_ready),
        .csr_op(csr_op), .scalar1(scalar1), .scalar2(scalar2),
        .rs1_is_x0(rs1_is_x0), .rd_is_x0(rd_is_x0),
        .vstart_wr_en(vstart_wr_en), .vstart_wr_data(vstart_wr_data),
        .resp_valid(resp_valid), .resp_vl(resp_vl),
        .vl_o(vl_o), .vtype_o(vtype_o), .vlmax_o(vlmax_o),
        .vsew_o(vsew_o), .vlmul_o(vlmul_o), .vill_o(vill_o), .vstart_o(vstart_o)
    );

    // Issue one request, then wait (bounded) for resp_valid; lat counts
    // falling edges after the accepting edge. Returns at the response cycle.
    task automatic issue(input logic [1:0] op, input logic [31:0] s1, input logic [31:0] s2,
                         input logic r1x0, input logic rdx0);
        int n;
        @(negedge clk);
        csr_req_valid = 1'b1; csr_op = op; scalar1 = s1; scalar2 = s2;
        rs1_is_x0 = r1x0; rd_is_x0 = rdx0;
        n = 0;
        while (!csr_req_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        csr_req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin @(negedge clk); lat++; end
    endtask

    task automatic test_reset;
        n_rst = 1'b0; csr_req_valid = 1'b0; csr_op = 2'b00; scalar1 = '0; scalar2 = '0;
        rs1_is_x0 = 1'b0; rd_is_x0 = 1'b0; vstart_wr_en = 1'b0; vstart_wr_data = '0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        checks++; if (vl_o !== 32'd0) begin errors++; $display("FAIL reset_vl got=%h exp=0", vl_o); end
        checks++; if (vtype_o !== 32'h8000_0000) begin errors++; $display("FAIL reset_vtype got=%h exp=80000000", vtype_o); end
        checks++; if (vlmax_o !== 32'd0) begin errors++; $display("FAIL reset_vlmax got=%h exp=0", vlmax_o); end
        checks++; if (vstart_o !== 32'd0) begin errors++; $display("FAIL reset_vstart got=%h exp=0", vstart_o); end
        checks++; if (csr_req_ready !== 1'b1 || resp_valid !== 1'b0 || vill_o !== 1'b1)
            begin errors++; $display("FAIL reset_ctrl ready=%b resp=%b vill=%b exp 1 0 1", csr_req_ready, resp_valid, vill_o); end
    endtask

    task automatic test_vsetvli;
        issue(2'b00, 32'd20, 32'h10, 1'b0, 1'b0);
        checks++; if (lat !== 3) begin errors++; $display("FAIL vsetvli_latency got=%0d exp=3", lat); end
        checks++; if (resp_vl !== 32'd16) begin errors++; $display("FAIL vsetvli_resp_vl got=%0d exp=16", resp_vl); end
        checks++; if (vl_o !== 32'd16 || vlmax_o !== 32'd16) begin errors++; $display("FAIL vsetvli_vl_vlmax got=%0d/%0d exp=16/16", vl_o, vlmax_o); end
        checks++; if (vtype_o !== 32'h10 || vsew_o !== 3'd2 || vlmul_o !== 3'd0 || vill_o !== 1'b0)
            begin errors++; $display("FAIL vsetvli_vtype got=%h sew=%0d lmul=%0d vill=%b exp=10 2 0 0", vtype_o, vsew_o, vlmul_o, vill_o); end
    endtask

    task automatic test_vsetvl;
        issue(2'b10, 32'd10, 32'h08, 1'b0, 1'b0);
        checks++; if (vl_o !== 32'd10 || vlmax_o !== 32'd32) begin errors++; $display("FAIL vsetvl got=%0d/%0d exp=10/32", vl_o, vlmax_o); end
    endtask

    task automatic test_vsetivli;
        // x0 flags must be ignored; otherwise the VLMAX change would make it illegal
        issue(2'b01, 32'hFFFF_FFE5, 32'h01, 1'b1, 1'b1);
        checks++; if (vl_o !== 32'd5 || vlmax_o !== 32'd128 || resp_vl !== 32'd5)
            begin errors++; $display("FAIL vsetivli got=%0d/%0d resp=%0d exp=5/128/5", vl_o, vlmax_o, resp_vl); end
    endtask

    task automatic test_avl_max;
        issue(2'b00, 32'd3, 32'h0A, 1'b1, 1'b0);
        checks++; if (vl_o !== 32'd128 || vlmax_o !== 32'd128) begin errors++; $display("FAIL avl_max got=%0d/%0d exp=128/128", vl_o, vlmax_o); end
        // rs1=rd=x0 with unchanged VLMAX keeps vl
        issue(2'b00, 32'd3, 32'h01, 1'b1, 1'b1);
        checks++; if (vl_o !== 32'd128 || vtype_o !== 32'h01) begin errors++; $display("FAIL keep_vl got=%0d vtype=%h exp=128 01", vl_o, vtype_o); end
        // large AVL clamps by unsigned compare
        issue(2'b00, 32'hFFFF_FFF0, 32'h10, 1'b0, 1'b0);
        checks++; if (vl_o !== 32'd16) begin errors++; $display("FAIL avl_unsigned got=%0d exp=16", vl_o); end
        // legal fractional LMUL: SEW8, LMUL1/2
        issue(2'b00, 32'd100, 32'h07, 1'b0, 1'b0);
        checks++; if (vl_o !== 32'd32 || vlmax_o !== 32'd32 || vill_o !== 1'b0)
            begin errors++; $display("FAIL frac_legal got=%0d/%0d vill=%b exp=32/32/0", vl_o, vlmax_o, vill_o); end
    endtask

    task automatic test_illegal;
        logic [1:0]  ops [5];
        logic [31:0] s2s [5];
        logic        x0s [5];
        ops = '{2'b00, 2'b00, 2'b10, 2'b11, 2'b00};
        s2s = '{32'h18, 32'h15, 32'h110, 32'h10, 32'h08};
        x0s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            // restore a legal state with vlmax 16 so vl/vlmax visibly drop to 0
            issue(2'b00, 32'd20, 32'h10, 1'b0, 1'b0);
            issue(ops[i], 32'd7, s2s[i], x0s[i], x0s[i]);
            checks++;
            if (vill_o !== 1'b1 || vl_o !== 32'd0 || vtype_o !== 32'h8000_0000 || vlmax_o !== 32'd0 || resp_vl !== 32'd0)
                begin errors++; $display("FAIL illegal_%0d vill=%b vl=%0d vtype=%h vlmax=%0d resp=%0d exp 1 0 80000000 0 0",
                                         i, vill_o, vl_o, vtype_o, vlmax_o, resp_vl); end
        end
    endtask

    task automatic test_vstart;
        @(negedge clk);
        vstart_wr_en = 1'b1; vstart_wr_data = 32'd7;
        @(negedge clk);
        vstart_wr_en = 1'b0;
        checks++; if (vstart_o !== 32'd7) begin errors++; $display("FAIL vstart_write got=%0d exp=7", vstart_o); end
        csr_req_valid = 1'b1; csr_op = 2'b00; scalar1 = 32'd4; scalar2 = 32'h10; rs1_is_x0 = 1'b0; rd_is_x0 = 1'b0;
        @(negedge clk);           // CALC
        csr_req_valid = 1'b0;
        @(negedge clk);           // COMMIT
        vstart_wr_en = 1'b1; vstart_wr_data = 32'd9;
        @(negedge clk);
        vstart_wr_en = 1'b0;
        checks++; if (vstart_o !== 32'd0 || resp_valid !== 1'b1) begin errors++; $display("FAIL vstart_commit got=%0d resp=%b exp=0 1", vstart_o, resp_valid); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        csr_req_valid = 1'b1; csr_op = 2'b00; scalar1 = 32'd20; scalar2 = 32'h10; rs1_is_x0 = 1'b0; rd_is_x0 = 1'b0;
        @(negedge clk);           // CALC: swap in second request, held until ready
        csr_op = 2'b10; scalar1 = 32'd40; scalar2 = 32'h08;
        checks++; if (csr_req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_calc got=%b exp=0", csr_req_ready); end
        @(negedge clk);           // COMMIT
        checks++; if (csr_req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_commit got=%b exp=0", csr_req_ready); end
        @(negedge clk);           // response A, second accepted at next edge
        checks++; if (resp_valid !== 1'b1 || resp_vl !== 32'd16 || csr_req_ready !== 1'b1)
            begin errors++; $display("FAIL b2b_first resp=%b vl=%0d ready=%b exp 1 16 1", resp_valid, resp_vl, csr_req_ready); end
        @(negedge clk);
        csr_req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse got=%b exp=0", resp_valid); end
        repeat (2) @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_vl !== 32'd32 || vl_o !== 32'd32)
            begin errors++; $display("FAIL b2b_second resp=%b vl=%0d vl_o=%0d exp 1 32 32", resp_valid, resp_vl, vl_o); end
    endtask

    task automatic test_reset_mid;
        int seen;
        @(negedge clk);
        csr_req_valid = 1'b1; csr_op = 2'b01; scalar1 = 32'd5; scalar2 = 32'h01; rs1_is_x0 = 1'b0; rd_is_x0 = 1'b0;
        vstart_wr_en = 1'b1; vstart_wr_data = 32'd3;
        @(negedge clk);           // CALC
        csr_req_valid = 1'b0; vstart_wr_en = 1'b0;
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid) seen++;
            @(negedge clk);
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_resp got=%0d pulses exp=0", seen); end
        checks++; if (vl_o !== 32'd0 || vtype_o !== 32'h8000_0000 || vlmax_o !== 32'd0 || vstart_o !== 32'd0 || csr_req_ready !== 1'b1)
            begin errors++; $display("FAIL rstmid_state vl=%0d vtype=%h vlmax=%0d vstart=%0d ready=%b exp 0 80000000 0 0 1",
                                     vl_o, vtype_o, vlmax_o, vstart_o, csr_req_ready); end
    endtask

    initial begin
        test_reset();
        test_vsetvli();
        test_vsetvl();
        test_vsetivli();
        test_avl_max();
        test_illegal();
        test_vstart();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
